// File: rtl/pacman_input_queue.sv
// Keycode-to-direction request queue for pacman: a small FIFO of turn requests that expire after
// HOLD_FRAMES frames, plus the pause toggle. Optional macro ARROW_KEYS_EN adds arrow-key mapping.
module pacman_input_queue #(
    parameter int          DEPTH       = 2,
    parameter int          HOLD_FRAMES = 8,
    parameter logic [1:0]  RESET_DIR   = 2'b10
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       dir_req_valid,
    output logic [1:0] dir_req,
    input  logic       dir_req_ack,
    output logic [1:0] cur_dir,
    output logic       paused,
    output logic [2:0] q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {EMPTY, PENDING, PAUSED} state_t;

    state_t          state_reg;
    logic [7:0]      kc_q, kc_p;
    logic [2:0]      fs_reg;
    logic [1:0]      mem_reg [DEPTH];
    logic [PW-1:0]   head_reg;
    logic [2:0]      count_reg;
    logic [1:0]      cur_dir_reg;
    logic [TW-1:0]   to_cnt_reg;

    logic [1:0]      key_dir;
    logic            key_is_dir, key_is_pause;
    logic            press, dir_press, pause_press, frame_tick;
    logic [PW-1:0]   tail_idx, push_idx;
    logic            full, dup, push, timeout_pop, pop;
    logic [2:0]      count_next;

    always_comb begin
        key_dir      = 2'b00;
        key_is_dir   = 1'b0;
        key_is_pause = 1'b0;
        case (kc_q)
            8'h1A: begin key_dir = 2'b00; key_is_dir = 1'b1; end
            8'h16: begin key_dir = 2'b01; key_is_dir = 1'b1; end
            8'h04: begin key_dir = 2'b10; key_is_dir = 1'b1; end
            8'h07: begin key_dir = 2'b11; key_is_dir = 1'b1; end
`ifdef ARROW_KEYS_EN
            8'h52: begin key_dir = 2'b00; key_is_dir = 1'b1; end
            8'h51: begin key_dir = 2'b01; key_is_dir = 1'b1; end
            8'h50: begin key_dir = 2'b10; key_is_dir = 1'b1; end
            8'h4F: begin key_dir = 2'b11; key_is_dir = 1'b1; end
`endif
            8'h13: key_is_pause = 1'b1;
            default: ;
        endcase
    end

    assign press       = (kc_q != kc_p) && (kc_q != 8'h00);
    assign dir_press   = press && key_is_dir;
    assign pause_press = press && key_is_pause;
    // fs_reg[1:0] is the synchronizer; fs_reg[2] is the delayed copy for edge detect
    assign frame_tick  = fs_reg[1] && !fs_reg[2];

    assign tail_idx = head_reg + PW'(count_reg - 3'd1);
    assign push_idx = head_reg + PW'(count_reg);
    assign full     = (count_reg == 3'(DEPTH));

    // Duplicate check always looks at the pre-pop tail, or cur_dir when nothing is queued
    assign dup  = (count_reg == 3'd0) ? (key_dir == cur_dir_reg) : (key_dir == mem_reg[tail_idx]);
    assign push = dir_press && !dup;

    assign timeout_pop = !dir_req_ack && frame_tick && (to_cnt_reg == TW'(HOLD_FRAMES - 1));
    assign pop         = dir_req_ack || timeout_pop;

    always_comb begin
        count_next = count_reg;
        if (pop && !push)
            count_next = count_reg - 3'd1;
        else if (push && !pop && !full)
            count_next = count_reg + 3'd1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg   <= EMPTY;
            kc_q        <= 8'h00;
            kc_p        <= 8'h00;
            fs_reg      <= 3'b000;
            head_reg    <= '0;
            count_reg   <= 3'd0;
            cur_dir_reg <= RESET_DIR;
            to_cnt_reg  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= 2'b00;
        end else begin
            kc_q   <= keycode;
            kc_p   <= kc_q;
            fs_reg <= {fs_reg[1:0], frame_clk};
            case (state_reg)
                EMPTY: begin
                    if (pause_press) begin
                        state_reg <= PAUSED;
                    end else if (push) begin
                        mem_reg[push_idx] <= key_dir;
                        count_reg         <= 3'd1;
                        state_reg         <= PENDING;
                    end
                end
                PENDING: begin
                    if (pause_press) begin
                        count_reg  <= 3'd0;
                        to_cnt_reg <= '0;
                        state_reg  <= PAUSED;
                    end else begin
                        if (dir_req_ack)
                            cur_dir_reg <= mem_reg[head_reg];
                        if (pop) begin
                            head_reg   <= head_reg + PW'(1);
                            to_cnt_reg <= '0;
                        end else if (frame_tick) begin
                            to_cnt_reg <= to_cnt_reg + TW'(1);
                        end
                        // When full and popping, push_idx lands on the slot being vacated
                        if (push) begin
                            if (full && !pop)
                                mem_reg[tail_idx] <= key_dir;
                            else
                                mem_reg[push_idx] <= key_dir;
                        end
                        count_reg <= count_next;
                        state_reg <= (count_next == 3'd0) ? EMPTY : PENDING;
                    end
                end
                PAUSED: begin
                    if (pause_press)
                        state_reg <= EMPTY;
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign dir_req_valid = (state_reg == PENDING);
    assign dir_req       = mem_reg[head_reg];
    assign paused        = (state_reg == PAUSED);
    assign q_count       = count_reg;
    assign cur_dir       = cur_dir_reg;
endmodule

// File: tb/tb_pacman_input_queue.sv
// Directed bench for pacman_input_queue: latency, dedup, overwrite, timeout, pause, ack+press, arrows.
module tb_pacman_input_queue;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       dir_req_valid;
    logic [1:0] dir_req;
    logic       dir_req_ack;
    logic [1:0] cur_dir;
    logic       paused;
    logic [2:0] q_count;

    int n_checks = 0;
    int n_fail   = 0;

    pacman_input_queue dut (
        .Clk           (clk),
        .Reset_n       (reset_n),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .dir_req_valid (dir_req_valid),
        .dir_req       (dir_req),
        .dir_req_ack   (dir_req_ack),
        .cur_dir       (cur_dir),
        .paused        (paused),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press then release a key; outputs are settled when this returns
    task automatic press(input logic [7:0] code);
        keycode = code;
        step(2);
        keycode = 8'h00;
        step(2);
        $display("press 0x%02h -> valid=%0b dir_req=%b q_count=%0d cur_dir=%b paused=%0b",
                 code, dir_req_valid, dir_req, q_count, cur_dir, paused);
    endtask

    task automatic ack_pulse();
        dir_req_ack = 1'b1;
        step(1);
        dir_req_ack = 1'b0;
        $display("ack -> valid=%0b dir_req=%b q_count=%0d cur_dir=%b", dir_req_valid, dir_req, q_count, cur_dir);
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        step(4);
        frame_clk = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; keycode = 8'h00; dir_req_ack = 1'b0; frame_clk = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        n_checks++; if (cur_dir !== 2'b10) begin n_fail++; $display("FAIL reset_cur_dir got=%b exp=10", cur_dir); end
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dir_req_valid); end
        n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused got=%b exp=0", paused); end
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", q_count); end
        n_checks++; if (dir_req !== 2'b00) begin n_fail++; $display("FAIL reset_dir_req got=%b exp=00", dir_req); end
        $display("reset done: cur_dir=%b valid=%0b q_count=%0d", cur_dir, dir_req_valid, q_count);
    endtask

    task automatic test_dup_cur_dir();
        press(8'h04);
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL dup_cur_dir_count got=%0d exp=0", q_count); end
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL dup_cur_dir_valid got=%b exp=0", dir_req_valid); end
    endtask

    task automatic test_latency();
        keycode = 8'h1A;
        step(1);
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL latency_1cyc got=%b exp=0", dir_req_valid); end
        step(1);
        n_checks++; if (dir_req_valid !== 1'b1) begin n_fail++; $display("FAIL latency_2cyc got=%b exp=1", dir_req_valid); end
        n_checks++; if (dir_req !== 2'b00) begin n_fail++; $display("FAIL latency_dir got=%b exp=00", dir_req); end
        keycode = 8'h00;
        step(2);
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b00) begin n_fail++; $display("FAIL ack_cur_dir got=%b exp=00", cur_dir); end
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL ack_count got=%0d exp=0", q_count); end
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid got=%b exp=0", dir_req_valid); end
    endtask

    task automatic test_overwrite();
        press(8'h07);
        press(8'h07);
        n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL tail_dup_count got=%0d exp=1", q_count); end
        press(8'h16);
        press(8'h04);
        n_checks++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL full_count got=%0d exp=2", q_count); end
        n_checks++; if (dir_req !== 2'b11) begin n_fail++; $display("FAIL full_head got=%b exp=11", dir_req); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b11) begin n_fail++; $display("FAIL pop1_cur_dir got=%b exp=11", cur_dir); end
        n_checks++; if (dir_req !== 2'b10) begin n_fail++; $display("FAIL overwritten_tail got=%b exp=10", dir_req); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b10) begin n_fail++; $display("FAIL pop2_cur_dir got=%b exp=10", cur_dir); end
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL pop2_count got=%0d exp=0", q_count); end
    endtask

    task automatic test_timeout();
        press(8'h1A);
        for (int i = 0; i < 7; i++) frame_pulse();
        $display("after 7 frames: q_count=%0d valid=%0b", q_count, dir_req_valid);
        n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL timeout_7_count got=%0d exp=1", q_count); end
        frame_pulse();
        $display("after 8 frames: q_count=%0d valid=%0b cur_dir=%b", q_count, dir_req_valid, cur_dir);
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL timeout_8_count got=%0d exp=0", q_count); end
        n_checks++; if (cur_dir !== 2'b10) begin n_fail++; $display("FAIL timeout_cur_dir got=%b exp=10", cur_dir); end
    endtask

    task automatic test_pause();
        press(8'h07);
        press(8'h16);
        n_checks++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL pause_fill got=%0d exp=2", q_count); end
        press(8'h13);
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_on got=%b exp=1", paused); end
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL pause_flush got=%0d exp=0", q_count); end
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL pause_valid got=%b exp=0", dir_req_valid); end
        press(8'h04);
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL pause_ignore got=%0d exp=0", q_count); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b10) begin n_fail++; $display("FAIL pause_ack got=%b exp=10", cur_dir); end
        press(8'h13);
        n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_off got=%b exp=0", paused); end
        press(8'h1A);
        n_checks++; if (dir_req_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid got=%b exp=1", dir_req_valid); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b00) begin n_fail++; $display("FAIL resume_ack got=%b exp=00", cur_dir); end
    endtask

    task automatic test_ack_press();
        press(8'h07);
        press(8'h04);
        keycode = 8'h16;
        step(1);
        dir_req_ack = 1'b1;
        step(1);
        dir_req_ack = 1'b0;
        keycode = 8'h00;
        step(2);
        $display("ack+press: cur_dir=%b q_count=%0d dir_req=%b", cur_dir, q_count, dir_req);
        n_checks++; if (cur_dir !== 2'b11) begin n_fail++; $display("FAIL ackpress_cur_dir got=%b exp=11", cur_dir); end
        n_checks++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL ackpress_count got=%0d exp=2", q_count); end
        n_checks++; if (dir_req !== 2'b10) begin n_fail++; $display("FAIL ackpress_head got=%b exp=10", dir_req); end
        ack_pulse();
        n_checks++; if (dir_req !== 2'b01) begin n_fail++; $display("FAIL ackpress_tail got=%b exp=01", dir_req); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b01) begin n_fail++; $display("FAIL ackpress_last got=%b exp=01", cur_dir); end
    endtask

    task automatic test_arrow();
        press(8'h50);
`ifdef ARROW_KEYS_EN
        n_checks++; if (dir_req_valid !== 1'b1) begin n_fail++; $display("FAIL arrow_valid got=%b exp=1", dir_req_valid); end
        n_checks++; if (dir_req !== 2'b10) begin n_fail++; $display("FAIL arrow_dir got=%b exp=10", dir_req); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b10) begin n_fail++; $display("FAIL arrow_ack got=%b exp=10", cur_dir); end
`else
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL arrow_ignored got=%b exp=0", dir_req_valid); end
        ack_pulse();
        n_checks++; if (cur_dir !== 2'b01) begin n_fail++; $display("FAIL idle_ack got=%b exp=01", cur_dir); end
`endif
    endtask

    task automatic test_reset_flush();
        press(8'h1A);
        n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL flush_pre got=%0d exp=1", q_count); end
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        $display("mid reset: q_count=%0d valid=%0b cur_dir=%b", q_count, dir_req_valid, cur_dir);
        n_checks++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", q_count); end
        n_checks++; if (cur_dir !== 2'b10) begin n_fail++; $display("FAIL flush_cur_dir got=%b exp=10", cur_dir); end
        n_checks++; if (dir_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", dir_req_valid); end
    endtask

    initial begin
        test_reset();
        test_dup_cur_dir();
        test_latency();
        test_overwrite();
        test_timeout();
        test_pause();
        test_ack_press();
        test_arrow();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
